// File: rtl/message_writer_if.sv
// Message RAM write port.
// master: driven by the writer (mem_we, mem_waddr, mem_wdata).
// slave:  observed by the RAM (or a bench monitor).
interface message_writer_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (output mem_we, output mem_waddr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_waddr, input  mem_wdata);
endinterface

// File: rtl/message_writer.sv
// Writer side of the scrolling-message RAM. Debounced write button stores the switch
// code at an auto-incrementing pointer; debounced clear button sweeps the whole RAM with
// BLANK_CODE.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   btn_wr_i     - raw write pushbutton (async, bouncy)
//   btn_clr_i    - raw clear pushbutton (async, bouncy)
//   char_in_i    - switch character code (async)
//   mem_if       - RAM write port (mem_we one-cycle pulses, mem_waddr, mem_wdata)
//   busy_o       - high while a clear sweep is in progress
//   full_o       - sticky: every location written since last clear/reset
module message_writer #(
    parameter int unsigned     ADDR_W     = 4,
    parameter int unsigned     DATA_W     = 4,
    parameter int unsigned     DEB_CYCLES = 16,
    parameter logic [DATA_W-1:0] BLANK_CODE = 4'hF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_wr_i,
    input  logic                btn_clr_i,
    input  logic [DATA_W-1:0]   char_in_i,
    message_writer_if.master    mem_if,
    output logic                busy_o,
    output logic                full_o
);

    localparam int unsigned      CntW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0]  CntMax  = CntW'(DEB_CYCLES - 1);
    localparam logic [ADDR_W-1:0] AddrMax = '1;
    localparam int unsigned      BtnWr   = 0;
    localparam int unsigned      BtnClr  = 1;

    typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

    // Synchronizers
    logic [1:0]        btn_meta_q, btn_sync_q;
    logic [DATA_W-1:0] char_meta_q, char_sync_q;

    // Debouncers, index BtnWr / BtnClr
    logic [1:0]        db_q, db_d;
    logic [1:0]        press_q, press_d;
    logic [CntW-1:0]   cnt_q [2];
    logic [CntW-1:0]   cnt_d [2];

    // FSM and registered outputs
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              full_q, full_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q  <= '0;
            btn_sync_q  <= '0;
            char_meta_q <= '0;
            char_sync_q <= '0;
        end else begin
            btn_meta_q  <= {btn_clr_i, btn_wr_i};
            btn_sync_q  <= btn_meta_q;
            char_meta_q <= char_in_i;
            char_sync_q <= char_meta_q;
        end
    end

    // A level change is accepted only after DEB_CYCLES consecutive differing samples;
    // any sample matching the current level restarts the count.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]    = db_q[i];
            cnt_d[i]   = cnt_q[i];
            press_d[i] = 1'b0;
            if (btn_sync_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                db_d[i]    = btn_sync_q[i];
                cnt_d[i]   = '0;
                press_d[i] = btn_sync_q[i];   // only 0->1 is an event
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q    <= '0;
            press_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q    <= db_d;
            press_q <= press_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        full_d  = full_q;
        unique case (state_q)
            StIdle: begin
                if (press_q[BtnClr]) begin
                    // Issue address 0 on the entry edge so busy covers exactly the
                    // 2**ADDR_W pulse cycles; mem_waddr doubles as the sweep counter.
                    state_d = StClear;
                    busy_d  = 1'b1;
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = BLANK_CODE;
                end else if (press_q[BtnWr]) begin
                    state_d = StWrite;
                    we_d    = 1'b1;
                    waddr_d = wptr_q;
                    wdata_d = char_sync_q;
                end
            end
            StWrite: begin
                wptr_d = wptr_q + ADDR_W'(1);
                if (wptr_q == AddrMax) begin
                    full_d = 1'b1;
                end
                state_d = StIdle;
            end
            StClear: begin
                if (waddr_q == AddrMax) begin
                    busy_d  = 1'b0;
                    wptr_d  = '0;
                    full_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + ADDR_W'(1);
                    wdata_d = BLANK_CODE;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            full_q  <= full_d;
        end
    end

    assign mem_if.mem_we    = we_q;
    assign mem_if.mem_waddr = waddr_q;
    assign mem_if.mem_wdata = wdata_q;
    assign busy_o           = busy_q;
    assign full_o           = full_q;

endmodule
